lua_arbiter: RTL and testbench
==============================

# lua_arbiter

Round-robin arbiter/sequencer sharing one `LUA` linear-address unit (Address = Y·BLOCK_SIZE + X) among `NUM_REQ` requesters. Sits between the requesters and a single `LUA` instance: it accepts level requests, runs the `LUA` Start/Ready handshake on behalf of the winner and returns the address with a one-cycle acknowledge. The `LUA` computation is never re-implemented here; the arbiter only drives and observes it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 16: width of each X/Y coordinate.
- `ADDR_WIDTH`, 32: width of `LUA` Address and `Result`.
- `TIMEOUT_CYCLES`, 64: watchdog limit, used only with `LUA_ARB_TIMEOUT_EN`.
- `Clk` in 1: sole clock, rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `Req` in NUM_REQ: per-requester request level.
- `ReqX` in NUM_REQ·DATA_WIDTH: packed X; requester i at bits [i·DATA_WIDTH +: DATA_WIDTH].
- `ReqY` in NUM_REQ·DATA_WIDTH: packed Y, same packing.
- `Ack` out NUM_REQ: one-hot, one-cycle completion pulse.
- `Result` out ADDR_WIDTH: address of the last completed job; valid while `Ack` pulses, held afterwards.
- `Err` out 1: pulses with `Ack` when the job timed out.
- `Busy` out 1: high in any state except IDLE.
- `LuaStart` out 1, `LuaX` out DATA_WIDTH, `LuaY` out DATA_WIDTH: to the `LUA` instance.
- `LuaAddress` in ADDR_WIDTH, `LuaReady` in 1: from the `LUA` instance.

## Operation
- Reset (async, `nReset`=0): state IDLE; `Ack`, `Err`, `Busy`, `LuaStart`, `LuaX`, `LuaY`, `Result` = 0; round-robin pointer = 0.
- Requester rule: hold `Req[i]` and its X/Y stable until `Ack[i]`. X/Y are sampled at grant. A `Req[i]` still high the cycle after `Ack[i]` counts as a new request.
- Round robin: search from the pointer upward, wrapping at NUM_REQ-1. The first set `Req` bit wins. After grant, pointer = winner+1 (mod NUM_REQ).
- States:
  - IDLE: if any `Req` and `LuaReady`=1 → register winner index, `LuaX`/`LuaY` ← winner coords, `LuaStart`←1 → ISSUE. `LuaReady`=0 blocks granting.
  - ISSUE: hold `LuaStart`=1. On `LuaReady`=0 → `LuaStart`←0 → WAIT.
  - WAIT: on `LuaReady`=1 → `Result`←`LuaAddress`, `Ack[winner]`←1 for one cycle → IDLE.
  - RECOVER (timeout builds only): `LuaStart`=0. On `LuaReady`=1 → IDLE.
- Dropping `Req[winner]` mid-job does not abort it; `Ack` is still issued.
- Requests arriving during a job wait; they do not preempt.
- Widths: `LuaX`/`LuaY` are copied verbatim; no arithmetic in the arbiter.

## Timing
- IDLE→ISSUE grant edge: `LuaStart`, `LuaX` and `LuaY` are registered and visible the cycle after the grant edge.
- Latency from `Req` high (IDLE, `LuaReady`=1) to `Ack`:
  - 1 cycle to grant,
  - plus the `LUA` time to drop `Ready`,
  - plus the `LUA` compute time,
  - plus 1 cycle to register `Result`/`Ack`.
- `Ack` is exactly one cycle wide. `Result` updates on the same edge that raises `Ack`.
- Back-to-back: the IDLE cycle after `Ack` may grant immediately, so the minimum gap between `Ack` pulses is the `LUA` job time + 2 cycles.
- Simultaneous requests: resolved by the pointer only; the lowest index wins after reset.
- `nReset` mid-job: all outputs drop asynchronously, no `Ack` is issued, the pointer returns to 0. Requesters re-present their requests.

## Configuration
- `LUA_ARB_TIMEOUT_EN` defined:
  - a cycle counter runs in ISSUE and WAIT;
  - on reaching `TIMEOUT_CYCLES`: `LuaStart`←0, `Result`←0, `Ack[winner]` and `Err` pulse one cycle, state → RECOVER.
- Undefined: no counter, no RECOVER state; `Err` is tied 0 and the arbiter waits indefinitely.

## Test plan
- `LUA` BLOCK_SIZE=10, only `Req[1]`, X=4, Y=5 → one `Ack[1]` pulse, `Result`=54, `Busy` returns to 0.
- `Req[0]` (X=1,Y=1) and `Req[2]` (X=3,Y=2) raised on the same cycle after reset → `Ack[0]` with `Result`=11 first, then `Ack[2]` with `Result`=23.
- All four `Req` held continuously for 5 jobs → `Ack` order 0,1,2,3,0.
- `nReset` pulsed while in WAIT → `LuaStart`/`Ack`/`Busy` = 0 immediately, no `Ack`; a fresh request afterwards completes normally.
- Requests with `LuaReady` forced 0 in IDLE → no grant and `LuaStart` stays 0 until `LuaReady`=1.
- `LUA_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16, stub `LUA` holding `LuaReady`=1 → `Ack` and `Err` pulse 16 cycles after `LuaStart` rises, `Result`=0; the next job succeeds once the real `LUA` is connected.

Source files
------------

// File: rtl/lua_arbiter.sv
// lua_arbiter: round-robin sequencer sharing one LUA linear-address unit
// among NUM_REQ requesters. Runs the LUA Start/Ready handshake for the
// granted requester and returns the address with a one-cycle Ack pulse.
//
// Optional feature macro: LUA_ARB_TIMEOUT_EN (watchdog + RECOVER state).
//
// Ports:
//   Clk, nReset         clock (rising edge), async active-low reset
//   Req[NUM_REQ]        per-requester request level
//   ReqX/ReqY           packed coordinates, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Ack[NUM_REQ]        one-hot, one-cycle completion pulse
//   Result              address of the last completed job (held)
//   Err                 pulses with Ack on a timed-out job
//   Busy                high whenever the sequencer is not idle
//   LuaStart/LuaX/LuaY  drive the LUA instance
//   LuaAddress/LuaReady observed from the LUA instance
module lua_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          Clk,
  input  logic                          nReset,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqX,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqY,
  output logic [NUM_REQ-1:0]            Ack,
  output logic [ADDR_WIDTH-1:0]         Result,
  output logic                          Err,
  output logic                          Busy,
  output logic                          LuaStart,
  output logic [DATA_WIDTH-1:0]         LuaX,
  output logic [DATA_WIDTH-1:0]         LuaY,
  input  logic [ADDR_WIDTH-1:0]         LuaAddress,
  input  logic                          LuaReady
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
`ifdef LUA_ARB_TIMEOUT_EN
  localparam logic [1:0] ST_RECOVER = 2'd3;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
`endif

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0] result_q, result_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  busy_q, busy_d;
`ifdef LUA_ARB_TIMEOUT_EN
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

  logic                  found_c;
  logic [IDX_W-1:0]      win_c;
  logic [SUM_W-1:0]      sum_c;
  logic [DATA_WIDTH-1:0] req_x_c [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_y_c [NUM_REQ];

  // Unpack the flat coordinate buses into per-requester lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_x_c[g] = ReqX[g*DATA_WIDTH +: DATA_WIDTH];
    assign req_y_c[g] = ReqY[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first set Req at or above the pointer, wrapping.
  always_comb begin : rr_search
    found_c = 1'b0;
    win_c   = '0;
    sum_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum_c = {1'b0, ptr_q} + SUM_W'(k);
      if (sum_c >= SUM_W'(NUM_REQ)) begin
        sum_c = sum_c - SUM_W'(NUM_REQ);
      end
      if (!found_c && Req[sum_c[IDX_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = sum_c[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    start_d  = start_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    ack_d    = '0;
`ifdef LUA_ARB_TIMEOUT_EN
    err_d    = 1'b0;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A busy LUA (Ready low) blocks any grant.
        if (found_c && LuaReady) begin
          win_d   = win_c;
          x_d     = req_x_c[win_c];
          y_d     = req_y_c[win_c];
          start_d = 1'b1;
          ptr_d   = (win_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_c + IDX_W'(1);
          state_d = ST_ISSUE;
`ifdef LUA_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        if (!LuaReady) begin
          start_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (LuaReady) begin
          result_d     = LuaAddress;
          ack_d[win_q] = 1'b1;
          state_d      = ST_IDLE;
        end
      end
`ifdef LUA_ARB_TIMEOUT_EN
      ST_RECOVER: begin
        start_d = 1'b0;
        if (LuaReady) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

`ifdef LUA_ARB_TIMEOUT_EN
    // Watchdog: a normal completion in the same cycle takes priority.
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != ST_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        start_d      = 1'b0;
        result_d     = '0;
        ack_d        = '0;
        ack_d[win_q] = 1'b1;
        err_d        = 1'b1;
        state_d      = ST_RECOVER;
      end
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge nReset) begin : regs
    if (!nReset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
`ifdef LUA_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      start_q  <= start_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifdef LUA_ARB_TIMEOUT_EN
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign Ack      = ack_q;
  assign Result   = result_q;
  assign Busy     = busy_q;
  assign LuaStart = start_q;
  assign LuaX     = x_q;
  assign LuaY     = y_q;

`ifdef LUA_ARB_TIMEOUT_EN
  assign Err = err_q;
`else
  // Without the watchdog a job can never fail.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_lua_arbiter.sv
// Bench for lua_arbiter: a behavioural LUA (BLOCK_SIZE=10) plus directed
// scenarios and a randomized round-robin run checked against a simple
// queue-free arbitration model.
module tb_lua_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic          Clk    = 1'b0;
  logic          nReset = 1'b0;
  logic [N-1:0]  req    = '0;
  logic [DW-1:0] rx [N];
  logic [DW-1:0] ry [N];
  logic [N*DW-1:0] req_x, req_y;

  logic [N-1:0]  ack;
  logic [AW-1:0] result;
  logic          err, busy, lua_start;
  logic [DW-1:0] lua_x, lua_y;
  logic [AW-1:0] lua_addr;
  logic          lua_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_x[k*DW +: DW] = rx[k];
      req_y[k*DW +: DW] = ry[k];
    end
  end

  lua_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Req(req), .ReqX(req_x), .ReqY(req_y),
    .Ack(ack), .Result(result), .Err(err), .Busy(busy),
    .LuaStart(lua_start), .LuaX(lua_x), .LuaY(lua_y),
    .LuaAddress(lua_addr), .LuaReady(lua_ready)
  );

  // Behavioural LUA: accepts Start while Ready, drops Ready after d1
  // cycles, computes for d2 cycles, then presents Y*10+X with Ready high.
  int            lphase = 0;
  int            lcnt   = 0;
  logic          lrdy   = 1'b1;
  logic [DW-1:0] lx = '0, ly = '0;
  logic [AW-1:0] laddr  = '0;
  int            lua_d1 = 1;
  int            lua_d2 = 1;
  bit            lua_hold_low = 1'b0;
  bit            lua_stub     = 1'b0;

  assign lua_ready = lrdy & ~lua_hold_low;
  assign lua_addr  = laddr;

  always @(posedge Clk) begin
    case (lphase)
      0: if (lua_start && lrdy && !lua_stub) begin
           lx <= lua_x; ly <= lua_y; lcnt <= lua_d1; lphase <= 1;
         end
      1: if (lcnt <= 1) begin
           lrdy <= 1'b0; lcnt <= lua_d2; lphase <= 2;
         end else lcnt <= lcnt - 1;
      default: if (lcnt <= 1) begin
           laddr <= 32'(ly) * 32'd10 + 32'(lx); lrdy <= 1'b1; lphase <= 0;
         end else lcnt <= lcnt - 1;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an Ack pulse; returns the number of negedges waited.
  task automatic wait_ack(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge Clk);
      cycles++;
    end while (ack == '0 && cycles < limit);
    if (ack == '0) chk("ack_wait_expired", 64'(ack != '0), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    nReset = 1'b0;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic set_req(input int i, input int x, input int y);
    rx[i] = DW'(x);
    ry[i] = DW'(y);
    req   = req | (N'(1) << i);
  endtask

  task automatic clr_req(input int i);
    req = req & ~(N'(1) << i);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int mptr;
    int win;
    int exp_res;
    bit pend [N];
    bit any;

    for (int i = 0; i < N; i++) begin rx[i] = '0; ry[i] = '0; pend[i] = 1'b0; end

    // Reset values
    nReset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ack",    64'(ack), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_start",  64'(lua_start), 64'(0));
    chk("rst_luax",   64'(lua_x), 64'(0));
    chk("rst_luay",   64'(lua_y), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_err",    64'(err), 64'(0));
    nReset = 1'b1;
    @(negedge Clk);

    // Single request, requester 1, X=4 Y=5
    set_req(1, 4, 5);
    @(negedge Clk);
    chk("t1_start", 64'(lua_start), 64'(1));
    chk("t1_luax",  64'(lua_x), 64'(4));
    chk("t1_luay",  64'(lua_y), 64'(5));
    chk("t1_busy",  64'(busy), 64'(1));
    wait_ack(40, c);
    chk("t1_latency", 64'(c), 64'(4));
    chk("t1_ack",    64'(ack), 64'(4'b0010));
    chk("t1_result", 64'(result), 64'(54));
    chk("t1_err",    64'(err), 64'(0));
    clr_req(1);
    @(negedge Clk);
    chk("t1_ack_width", 64'(ack), 64'(0));
    chk("t1_idle",      64'(busy), 64'(0));
    chk("t1_hold",      64'(result), 64'(54));

    // Simultaneous requests 0 and 2 after reset
    do_reset();
    set_req(0, 1, 1);
    set_req(2, 3, 2);
    wait_ack(40, c);
    chk("t2_ack0", 64'(ack), 64'(4'b0001));
    chk("t2_res0", 64'(result), 64'(11));
    clr_req(0);
    wait_ack(40, c);
    chk("t2_ack2", 64'(ack), 64'(4'b0100));
    chk("t2_res2", 64'(result), 64'(23));
    chk("t2_gap",  64'(c), 64'(5));
    clr_req(2);

    // All four held for five jobs: order 0,1,2,3,0 and minimum gap
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i + 2, i * 3);
    for (int j = 0; j < 5; j++) begin
      wait_ack(40, c);
      chk($sformatf("t3_ack%0d", j), 64'(ack), 64'(N'(1) << (j % N)));
      chk($sformatf("t3_res%0d", j), 64'(result), 64'((j % N) * 30 + (j % N) + 2));
      chk($sformatf("t3_gap%0d", j), 64'(c), 64'(5));
    end
    req = '0;
    @(negedge Clk);
    chk("t3_idle", 64'(busy), 64'(0));

    // Reset while in WAIT: outputs drop at once, no Ack, request completes later
    lua_d1 = 1; lua_d2 = 10;
    set_req(3, 7, 2);
    c = 0;
    do begin @(negedge Clk); c++; end while (!(busy && !lua_start) && c < 20);
    chk("t4_reached_wait", 64'(busy && !lua_start), 64'(1));
    nReset = 1'b0;
    #1;
    chk("t4_start", 64'(lua_start), 64'(0));
    chk("t4_ack",   64'(ack), 64'(0));
    chk("t4_busy",  64'(busy), 64'(0));
    @(negedge Clk);
    chk("t4_ack_hold", 64'(ack), 64'(0));
    nReset = 1'b1;
    wait_ack(80, c);
    chk("t4_ack_after",  64'(ack), 64'(4'b1000));
    chk("t4_res_after",  64'(result), 64'(27));
    clr_req(3);
    lua_d2 = 1;
    @(negedge Clk);

    // LuaReady low in IDLE blocks granting
    lua_hold_low = 1'b1;
    set_req(1, 9, 9);
    for (int j = 0; j < 6; j++) begin
      @(negedge Clk);
      chk($sformatf("t5_nostart%0d", j), 64'(lua_start), 64'(0));
      chk($sformatf("t5_nobusy%0d", j),  64'(busy), 64'(0));
    end
    lua_hold_low = 1'b0;
    wait_ack(40, c);
    chk("t5_ack", 64'(ack), 64'(4'b0010));
    chk("t5_res", 64'(result), 64'(99));
    clr_req(1);
    @(negedge Clk);

`ifdef LUA_ARB_TIMEOUT_EN
    // Stub LUA never drops Ready: watchdog fires TO cycles after LuaStart
    lua_stub = 1'b1;
    set_req(2, 3, 2);
    c = 0;
    do begin @(negedge Clk); c++; end while (!lua_start && c < 10);
    chk("t6_started", 64'(lua_start), 64'(1));
    wait_ack(40, c);
    chk("t6_timeout_cycles", 64'(c), 64'(TO));
    chk("t6_ack", 64'(ack), 64'(4'b0100));
    chk("t6_err", 64'(err), 64'(1));
    chk("t6_res", 64'(result), 64'(0));
    clr_req(2);
    lua_stub = 1'b0;
    set_req(0, 1, 1);
    wait_ack(60, c);
    chk("t6_next_ack", 64'(ack), 64'(4'b0001));
    chk("t6_next_res", 64'(result), 64'(11));
    chk("t6_next_err", 64'(err), 64'(0));
    clr_req(0);
    @(negedge Clk);
`endif

    // Randomized run against a round-robin reference model
    do_reset();
    mptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!any) begin
        win = $urandom_range(0, N - 1);
        pend[win] = 1'b1;
        rx[win] = DW'($urandom_range(0, 999));
        ry[win] = DW'($urandom_range(0, 999));
      end
      req = '0;
      for (int i = 0; i < N; i++) if (pend[i]) req = req | (N'(1) << i);
      lua_d1 = $urandom_range(1, 3);
      lua_d2 = $urandom_range(1, 4);
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(mptr + k) % N]) win = (mptr + k) % N;
      end
      mptr = (win + 1) % N;
      exp_res = int'(ry[win]) * 10 + int'(rx[win]);
      wait_ack(60, c);
      chk($sformatf("rnd_ack%0d", j), 64'(ack), 64'(N'(1) << win));
      chk($sformatf("rnd_res%0d", j), 64'(result), 64'(exp_res));
      chk($sformatf("rnd_err%0d", j), 64'(err), 64'(0));
      pend[win] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rx[i] = DW'($urandom_range(0, 999));
          ry[i] = DW'($urandom_range(0, 999));
        end
      end
      req = '0;
      for (int i = 0; i < N; i++) if (pend[i]) req = req | (N'(1) << i);
    end
    req = '0;
    repeat (2) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
